// File: rtl/main_mem_ctrl.sv
// Main-memory model behind the cache controller: fixed access latency, then either a
// whole-block read burst (one word per cycle) or a single-word write commit.
`timescale 1ns/1ps
module main_mem_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int LATENCY     = 4,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                MStrobe,
    input  logic                MRW,
    input  logic [ADDR_W-1:0]   MAddr,
    input  logic [DATA_W-1:0]   MDataIn,
    output logic [DATA_W-1:0]   MDataOut,
    output logic                MWordValid,
    output logic [((BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1)-1:0] MWordIdx,
    output logic                MRdy,
    output logic                MBusy,
    output logic                MErr
);

    localparam int IDX_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BLOCK_WORDS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic                rw_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [ADDR_W-1:0]   blk_base;
    logic [ADDR_W-1:0]   rd_addr_next;
    logic [IDX_W-1:0]    idx_next;
    logic                commit;

    // The block index only ever fills the low bits, so a burst cannot leave its aligned block.
    assign blk_base     = addr_q & ~OFF_MASK;
    assign idx_next     = MWordIdx + IDX_W'(1);
    assign rd_addr_next = blk_base | ADDR_W'(idx_next);
    assign commit       = !reset && (state == WAIT) && (cnt == '0) && rw_q;
    assign MBusy        = (state != IDLE);

    // Request fields are captured once so the bus may change freely during the access.
    always_ff @(posedge clk) begin
        if (state == IDLE && MStrobe) begin
            addr_q <= MAddr;
            rw_q   <= MRW;
            data_q <= MDataIn;
        end
    end

    // Array has no reset: contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (commit)
            mem[addr_q] <= data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            MDataOut   <= '0;
            MWordValid <= 1'b0;
            MWordIdx   <= '0;
            MRdy       <= 1'b0;
            MErr       <= 1'b0;
        end else begin
            MRdy <= 1'b0;
            if (MStrobe && state != IDLE)
                MErr <= 1'b1;
            case (state)
                IDLE: begin
                    if (MStrobe) begin
                        cnt   <= CNT_W'(LATENCY - 1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (rw_q) begin
                        MRdy  <= 1'b1;
                        state <= DONE;
                    end else begin
                        MWordIdx   <= '0;
                        MWordValid <= 1'b1;
                        MDataOut   <= mem[blk_base];
                        MRdy       <= (BLOCK_WORDS == 1);
                        state      <= XFER;
                    end
                end
                XFER: begin
                    if (MWordIdx == LAST_IDX) begin
                        MWordValid <= 1'b0;
                        MWordIdx   <= '0;
                        state      <= IDLE;
                    end else begin
                        MWordIdx <= idx_next;
                        MDataOut <= mem[rd_addr_next];
                        MRdy     <= (idx_next == LAST_IDX);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Scoreboard bench for main_mem_ctrl: a default instance and a LATENCY=1/BLOCK_WORDS=1 instance,
// each with an expected-response queue filled at issue time and drained by its own monitor.
`timescale 1ns/1ps
module tb_main_mem_ctrl;

    localparam int A_LAT = 4;
    localparam int A_BW  = 4;
    localparam int B_LAT = 1;
    localparam int B_BW  = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic       a_rst, a_stb, a_rw;
    logic [7:0] a_addr, a_din, a_dout;
    logic       a_wv, a_rdy, a_busy, a_err;
    logic [1:0] a_idx;

    logic       b_rst, b_stb, b_rw;
    logic [7:0] b_addr, b_din, b_dout;
    logic       b_wv, b_rdy, b_busy, b_err;
    logic [0:0] b_idx;

    main_mem_ctrl #(.ADDR_W(8), .DATA_W(8), .LATENCY(A_LAT), .BLOCK_WORDS(A_BW)) dut_a (
        .clk(clk), .reset(a_rst), .MStrobe(a_stb), .MRW(a_rw), .MAddr(a_addr), .MDataIn(a_din),
        .MDataOut(a_dout), .MWordValid(a_wv), .MWordIdx(a_idx), .MRdy(a_rdy), .MBusy(a_busy), .MErr(a_err)
    );

    main_mem_ctrl #(.ADDR_W(8), .DATA_W(8), .LATENCY(B_LAT), .BLOCK_WORDS(B_BW)) dut_b (
        .clk(clk), .reset(b_rst), .MStrobe(b_stb), .MRW(b_rw), .MAddr(b_addr), .MDataIn(b_din),
        .MDataOut(b_dout), .MWordValid(b_wv), .MWordIdx(b_idx), .MRdy(b_rdy), .MBusy(b_busy), .MErr(b_err)
    );

    typedef struct {
        int         cyc;
        bit         valid;
        int         idx;
        logic [7:0] data;
        bit         rdy;
    } exp_t;

    exp_t       a_q[$];
    exp_t       b_q[$];
    logic [7:0] a_mem [256];
    logic [7:0] b_mem [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: a read returns the aligned block starting at (addr / BW) * BW, first word
    // LAT+1 cycles after the strobe; a write answers with MRdy LAT+1 cycles after the strobe.
    task automatic a_issue(input bit rw, input logic [7:0] addr, input logic [7:0] data, input bit expect_resp);
        exp_t e;
        logic [7:0] base;
        int t;
        t = cyc;
        a_stb = 1'b1; a_rw = rw; a_addr = addr; a_din = data;
        if (expect_resp) begin
            if (rw) begin
                a_mem[addr] = data;
                e.cyc = t + A_LAT + 1; e.valid = 1'b0; e.idx = 0; e.data = 8'h00; e.rdy = 1'b1;
                a_q.push_back(e);
            end else begin
                base = 8'((int'(addr) / A_BW) * A_BW);
                for (int i = 0; i < A_BW; i++) begin
                    e.cyc = t + A_LAT + 1 + i; e.valid = 1'b1; e.idx = i;
                    e.data = a_mem[base + 8'(i)]; e.rdy = (i == A_BW - 1);
                    a_q.push_back(e);
                end
            end
        end
        step();
        a_stb = 1'b0; a_rw = 1'($urandom); a_addr = 8'($urandom); a_din = 8'($urandom);
    endtask

    task automatic b_issue(input bit rw, input logic [7:0] addr, input logic [7:0] data);
        exp_t e;
        int t;
        t = cyc;
        b_stb = 1'b1; b_rw = rw; b_addr = addr; b_din = data;
        if (rw) begin
            b_mem[addr] = data;
            e.cyc = t + B_LAT + 1; e.valid = 1'b0; e.idx = 0; e.data = 8'h00; e.rdy = 1'b1;
        end else begin
            e.cyc = t + B_LAT + 1; e.valid = 1'b1; e.idx = 0; e.data = b_mem[addr]; e.rdy = 1'b1;
        end
        b_q.push_back(e);
        step();
        b_stb = 1'b0; b_rw = 1'($urandom); b_addr = 8'($urandom); b_din = 8'($urandom);
    endtask

    task automatic a_wait_rdy();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (a_rdy === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL a_timeout: no MRdy within 40 cycles, required one (cycle %0d)", cyc);
        end else begin
            step();
        end
    endtask

    task automatic b_wait_rdy();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (b_rdy === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL b_timeout: no MRdy within 40 cycles, required one (cycle %0d)", cyc);
        end else begin
            step();
        end
    endtask

    initial begin : mon_a
        exp_t e;
        forever begin
            @(negedge clk);
            if (a_wv === 1'b1 || a_rdy === 1'b1) begin
                checks++;
                if (a_q.size() == 0) begin
                    errors++;
                    $display("FAIL a_unexpected: got v=%b r=%b i=%0d d=%h at cycle %0d, required no output",
                             a_wv, a_rdy, a_idx, a_dout, cyc);
                end else begin
                    e = a_q.pop_front();
                    if (cyc != e.cyc || a_wv !== e.valid || a_rdy !== e.rdy ||
                        (e.valid && (a_idx !== 2'(e.idx) || a_dout !== e.data))) begin
                        errors++;
                        $display("FAIL a_resp: got cyc=%0d v=%b i=%0d d=%h r=%b, required cyc=%0d v=%b i=%0d d=%h r=%b",
                                 cyc, a_wv, a_idx, a_dout, a_rdy, e.cyc, e.valid, e.idx, e.data, e.rdy);
                    end
                end
            end
        end
    end

    initial begin : mon_b
        exp_t e;
        forever begin
            @(negedge clk);
            if (b_wv === 1'b1 || b_rdy === 1'b1) begin
                checks++;
                if (b_q.size() == 0) begin
                    errors++;
                    $display("FAIL b_unexpected: got v=%b r=%b i=%0d d=%h at cycle %0d, required no output",
                             b_wv, b_rdy, b_idx, b_dout, cyc);
                end else begin
                    e = b_q.pop_front();
                    if (cyc != e.cyc || b_wv !== e.valid || b_rdy !== e.rdy ||
                        (e.valid && (b_idx !== 1'(e.idx) || b_dout !== e.data))) begin
                        errors++;
                        $display("FAIL b_resp: got cyc=%0d v=%b i=%0d d=%h r=%b, required cyc=%0d v=%b i=%0d d=%h r=%b",
                                 cyc, b_wv, b_idx, b_dout, b_rdy, e.cyc, e.valid, e.idx, e.data, e.rdy);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [7:0] ad, dt;
        a_rst = 1'b1; a_stb = 1'b0; a_rw = 1'b0; a_addr = '0; a_din = '0;
        b_rst = 1'b1; b_stb = 1'b0; b_rw = 1'b0; b_addr = '0; b_din = '0;
        repeat (2) step();

        chk("rst_a_dout", a_dout, 0); chk("rst_a_wv", a_wv, 0); chk("rst_a_idx", a_idx, 0);
        chk("rst_a_rdy", a_rdy, 0);   chk("rst_a_busy", a_busy, 0); chk("rst_a_err", a_err, 0);
        chk("rst_b_dout", b_dout, 0); chk("rst_b_wv", b_wv, 0); chk("rst_b_rdy", b_rdy, 0);
        chk("rst_b_busy", b_busy, 0); chk("rst_b_err", b_err, 0);
        a_rst = 1'b0; b_rst = 1'b0;
        step();

        // Give every word a known value through the normal write path.
        for (int i = 0; i < 256; i++) begin
            a_issue(1'b1, 8'(i), 8'($urandom), 1'b1);
            a_wait_rdy();
        end
        for (int i = 0; i < 256; i++) begin
            b_issue(1'b1, 8'(i), 8'($urandom));
            b_wait_rdy();
        end

        // Write then read of the containing block, issued the cycle after MRdy.
        a_issue(1'b1, 8'h12, 8'hA5, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            chk("t1_busy_high", a_busy, 1);
            step();
        end
        chk("t1_busy_low", a_busy, 0);
        a_issue(1'b0, 8'h10, 8'h00, 1'b1);
        a_wait_rdy();

        // Unaligned read returns the whole aligned block in order.
        for (int i = 0; i < 4; i++) begin
            a_issue(1'b1, 8'(8'h20 + i), 8'(i + 1), 1'b1);
            a_wait_rdy();
        end
        a_issue(1'b0, 8'h22, 8'h00, 1'b1);
        a_wait_rdy();

        // Top block of memory.
        a_issue(1'b0, 8'hFF, 8'h00, 1'b1);
        a_wait_rdy();

        // Strobe while busy is ignored but flagged.
        a_issue(1'b0, 8'h40, 8'h00, 1'b1);
        chk("t3_err_idle", a_err, 0);
        step();
        a_stb = 1'b1; a_rw = 1'b1; a_addr = 8'h20; a_din = 8'hFF;
        chk("t3_err_before", a_err, 0);
        step();
        a_stb = 1'b0;
        chk("t3_err_set", a_err, 1);
        a_wait_rdy();
        a_issue(1'b0, 8'h20, 8'h00, 1'b1);
        a_wait_rdy();
        chk("t3_err_sticky", a_err, 1);

        // Reset during WAIT discards the uncommitted write.
        a_issue(1'b1, 8'h30, 8'h5A, 1'b0);
        step();
        a_rst = 1'b1;
        step();
        a_rst = 1'b0;
        chk("t4_busy", a_busy, 0); chk("t4_err", a_err, 0); chk("t4_wv", a_wv, 0);
        chk("t4_rdy", a_rdy, 0);   chk("t4_idx", a_idx, 0); chk("t4_dout", a_dout, 0);
        repeat (8) step();
        a_issue(1'b0, 8'h30, 8'h00, 1'b1);
        a_wait_rdy();

        // Randomized traffic, sometimes reading back a just-written word.
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) step();
            ad = 8'($urandom); dt = 8'($urandom);
            a_issue(1'($urandom), ad, dt, 1'b1);
            a_wait_rdy();
            if ($urandom_range(0, 2) == 0) begin
                a_issue(1'b0, ad, 8'h00, 1'b1);
                a_wait_rdy();
            end
        end

        // Minimal latency and single-word blocks.
        b_issue(1'b1, 8'h05, 8'h77);
        chk("t5_busy_wait", b_busy, 1);
        step();
        chk("t5_busy_done", b_busy, 1);
        step();
        chk("t5_busy_idle", b_busy, 0);
        b_issue(1'b0, 8'h05, 8'h00);
        b_wait_rdy();
        for (int n = 0; n < 20; n++) begin
            ad = 8'($urandom);
            b_issue(1'b1, ad, 8'($urandom));
            b_wait_rdy();
            b_issue(1'b0, ad, 8'h00);
            b_wait_rdy();
            b_issue(1'b0, 8'($urandom), 8'h00);
            b_wait_rdy();
        end
        chk("b_err_clear", b_err, 0);

        repeat (6) step();
        chk("a_queue_drained", a_q.size(), 0);
        chk("b_queue_drained", b_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
